// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential fetches to a variable-latency memory,
// buffers returned instructions with their PC, and presents the head to decode.
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall_d,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0]   CZERO   = {CW{1'b0}};
    localparam logic [AW-1:0]   PZERO   = {AW{1'b0}};

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];

    logic [CW:0]   credit_s;
    logic          req_fire_s;
    logic          resp_s;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] fire_w_s;
    logic [CW-1:0] resp_w_s;
    logic [CW-1:0] push_w_s;
    logic [CW-1:0] pop_w_s;

    // Credits cover both buffered entries and requests still out at the memory.
    assign credit_s       = {1'b0, count_q} + {1'b0, inflight_q};
    assign imem_req_valid = rst & ~redirect & (credit_s < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire_s     = imem_req_valid & imem_req_ready;
    assign resp_s         = rst & imem_resp_valid & (inflight_q != CZERO);
    assign push_s         = resp_s & ~redirect & (drop_q == CZERO);
    assign instr_valid    = rst & (count_q != CZERO);
    assign pop_s          = instr_valid & ~stall_d & ~redirect;

    assign fire_w_s = {{(CW-1){1'b0}}, req_fire_s};
    assign resp_w_s = {{(CW-1){1'b0}}, resp_s};
    assign push_w_s = {{(CW-1){1'b0}}, push_s};
    assign pop_w_s  = {{(CW-1){1'b0}}, pop_s};

    // Next-state: a redirect flushes the queue and turns every surviving request into a drop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            count_d    = CZERO;
            head_d     = PZERO;
            tail_d     = PZERO;
            inflight_d = inflight_q - resp_w_s;
            drop_d     = inflight_q - resp_w_s;
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            inflight_d = inflight_q + fire_w_s - resp_w_s;
            if (resp_s && (drop_q != CZERO)) begin
                drop_d = drop_q - {{(CW-1){1'b0}}, 1'b1};
            end else begin
                drop_d = drop_q;
            end
            if (push_s) begin
                tail_d    = tail_q + {{(AW-1){1'b0}}, 1'b1};
                resp_pc_d = resp_pc_q + 32'd4;
            end else begin
                tail_d    = tail_q;
                resp_pc_d = resp_pc_q;
            end
            if (pop_s) begin
                head_d = head_q + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                head_d = head_q;
            end
            count_d = count_q + push_w_s - pop_w_s;
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= CZERO;
            inflight_q <= CZERO;
            drop_q     <= CZERO;
            head_q     <= PZERO;
            tail_q     <= PZERO;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Entry storage; contents are only meaningful while counted, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_mem_q[tail_q] <= imem_resp_data;
            pc_mem_q[tail_q]    <= resp_pc_q;
        end
    end

    // Head presentation, falling back to a NOP bubble when nothing is buffered.
    always_comb begin
        if (instr_valid) begin
            instr_out    = instr_mem_q[head_q];
            pc_out       = pc_mem_q[head_q];
            pc_plus4_out = pc_mem_q[head_q] + 32'd4;
        end else begin
            instr_out    = NOP_INSTR;
            pc_out       = 32'd0;
            pc_plus4_out = 32'd0;
        end
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front end sitting directly upstream of the IF/ID pipeline register.
- Issues sequential fetch requests to a variable-latency instruction memory over a valid/ready request channel and an in-order response channel.
- Buffers returned instructions with their PC and PC+4 in a small FIFO, and presents the head to decode.
- Honours decode stall and execute-stage redirects (taken branch/jump/jalr), discarding stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries and maximum outstanding requests (power of 2, >=2)
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction driven on instr_out when the queue is empty (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  fetch address (word aligned)
imem_resp_valid  input  1  response data valid (in order, one per accepted request)
imem_resp_data  input  32  fetched instruction
redirect  input  1  execute-stage PC redirect (pc_src != 0)
redirect_pc  input  32  redirect target
stall_d  input  1  decode stall; head is not consumed
instr_valid  output  1  head entry valid
instr_out  output  32  head instruction, or NOP_INSTR when empty
pc_out  output  32  head PC, 0 when empty
pc_plus4_out  output  32  pc_out + 4, 0 when empty

Behaviour:
- State: fetch_pc (32b), FIFO of DEPTH entries {instr, pc}, count, inflight (requests accepted but not yet returned), drop (stale responses still to discard).
- Reset (rst==0 at posedge): fetch_pc=RESET_PC, count=inflight=drop=0, pointers=0. While rst==0, imem_req_valid=0 and instr_valid=0. Then instr_out=NOP_INSTR, pc_out=0, pc_plus4_out=0. Reset mid-operation abandons all in-flight responses. The memory is reset by the same rst.
- Request issue: imem_req_valid = rst & ~redirect & (count + inflight < DEPTH). imem_req_addr = fetch_pc.
- On handshake (valid & ready): fetch_pc += 4 (wraps mod 2^32), inflight += 1.
- Response, redirect==0: inflight -= 1. If drop>0, then drop -= 1 and the data is discarded. Otherwise push {imem_resp_data, pc} at the tail, where pc is the address of the oldest non-dropped in-flight request; track it with a resp_pc register that advances by 4 per pushed response. A response with inflight==0 is a protocol error and is ignored.
- Pop: when instr_valid & ~stall_d & ~redirect, advance head and count -= 1.
- Simultaneous push and pop: count unchanged. Push into a full FIFO cannot occur, because credits guarantee count + inflight <= DEPTH.
- Redirect (has priority over everything):
  - FIFO cleared (count=0, pointers reset).
  - fetch_pc = resp_pc = redirect_pc.
  - No request issued this cycle.
  - drop = inflight - resp, where resp = imem_resp_valid this cycle. A response arriving in the redirect cycle is discarded; inflight is updated identically.
  - First post-redirect request goes out the next cycle.
- Back-to-back redirects: each one re-aims fetch_pc. drop keeps covering all pre-redirect requests.
- Latency: request accepted at cycle N, response at N+k (k>=1). The entry is pushed at the N+k edge, and instr_valid is high at cycle N+k+1 (registered FIFO, output combinational from head).
- Outputs instr_out/pc_out/pc_plus4_out are combinational from the head entry. When count==0 they take the empty values: NOP_INSTR, 0, 0.
- Widths: count and inflight are log2(DEPTH)+1 bits. drop never exceeds inflight.

Test Plan:
- Reset then zero-wait memory (ready=1, k=1), stall_d=0:
  - imem_req_addr sequence 0,4,8,C…
  - instr_valid first high 2 cycles after reset release.
  - pc_out 0,4,8 in consecutive cycles, pc_plus4_out = pc_out+4.
- stall_d=1 held 10 cycles with k=1: exactly DEPTH=4 entries fill, imem_req_valid drops to 0, and head stays pc_out=0. On release, 0,4,8,C drain in order and fetch resumes at 0x10.
- k=3 latency, redirect to 0x100 with 2 requests in flight:
  - The 2 stale responses are discarded, drop returns to 0.
  - First valid output has pc_out=0x100 and the data from the 0x100 response.
- Redirect in the same cycle as a response and as pop:
  - Response discarded, queue empty next cycle with instr_out=0x00000013.
  - No request in the redirect cycle.
  - Next request address = redirect_pc.
- fetch_pc=0xFFFF_FFFC: next request address wraps to 0x0000_0000, and pc_plus4_out for the 0xFFFF_FFFC entry is 0.
- Assert rst=0 with 3 requests outstanding and FIFO half full:
  - Next cycle instr_valid=0, imem_req_valid=0.
  - After release, first request address = RESET_PC.
